room_icon_plotter: RTL and testbench

Sprite plotter that consumes one draw request (top-left x/y coordinate plus icon select) from the room-status datapath and writes the icon pixel by pixel to the VGA adapter's x/y/colour/plot port. It sits between the room coordinate datapath and the 160x120 VGA adapter. It is the drawing end of the coordinate interface: the datapath picks where to draw, and this block performs the write. Requests are accepted one at a time with a valid/ready handshake.

---
 rtl/room_icon_plotter.sv | 196 +++++++++++++++++++
 tb/tb_room_icon_plotter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/room_icon_plotter.sv
// room_icon_plotter
//   Takes one draw request (top-left x/y, icon select, erase flag) and
//   writes the icon to the VGA adapter one pixel per clock.
//   Pixels that fall off the visible screen have vga_plot held low.
//
//   Ports:
//     clock, reset        rising-edge clock, synchronous active-high reset
//     req_valid/req_ready request handshake (ready only in IDLE, not in reset)
//     req_x, req_y        sprite top-left coordinate
//     req_icon            0=L, 1=D, 2=solid block, 3=hollow frame
//     req_erase           write every sprite pixel as black
//     vga_x, vga_y        registered pixel coordinate
//     vga_colour          registered pixel colour
//     vga_plot            registered write strobe
//     busy                high while pixels are being emitted
//     done                one-cycle pulse after the last pixel
//
//   Optional feature macro: ROOM_PLOTTER_CLEAR_ON_RESET_EN
//     When defined, the block blanks the whole screen after reset
//     (CLEAR state) before it accepts its first request.
module room_icon_plotter #(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [1:0] req_icon,
  input  logic       req_erase,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);
  localparam int CW   = $clog2(SPRITE_W);
  localparam int RW   = $clog2(SPRITE_H);
  localparam int IW   = CW + RW;
  localparam int NPIX = SPRITE_W * SPRITE_H;

`ifdef ROOM_PLOTTER_CLEAR_ON_RESET_EN
  localparam int SXW = $clog2(SCREEN_W);
  localparam int SYW = $clog2(SCREEN_H);
  typedef enum logic [1:0] {IDLE, DRAW, DONE, CLEAR} state_t;
  logic [SXW-1:0] sx;
  logic [SYW-1:0] sy;
  logic           clr_fin;   // every screen pixel has been emitted
`else
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
`endif

  state_t        state;
  logic [7:0]    base_x;
  logic [6:0]    base_y;
  logic [1:0]    icon;
  logic          erase;
  logic [IW-1:0] cnt;        // index of the pixel currently presented

  // Opaque icon bitmaps; returns the colour for sprite cell (r,c).
  function automatic logic [2:0] pix_colour(logic [1:0] ic, logic er, int r, int c);
    logic       on;
    logic [2:0] col;
    case (ic)
      2'd0: begin
        on  = (c == 1 && r >= 1 && r <= 6) || (r == 6 && c >= 1 && c <= 6);
        col = 3'b110;
      end
      2'd1: begin
        on  = (c == 1 && r >= 1 && r <= 6) ||
              ((r == 1 || r == 6) && c >= 1 && c <= 5) ||
              (c == 6 && r >= 2 && r <= 5);
        col = 3'b010;
      end
      2'd2: begin
        on  = 1'b1;
        col = 3'b100;
      end
      default: begin
        on  = (r == 0) || (r == SPRITE_H-1) || (c == 0) || (c == SPRITE_W-1);
        col = 3'b111;
      end
    endcase
    return (er || !on) ? 3'b000 : col;
  endfunction

  // Next pixel to present: in IDLE it is pixel 0 of the incoming request,
  // otherwise the successor of the latched request's current pixel.
  logic [7:0]    sel_x;
  logic [6:0]    sel_y;
  logic [1:0]    sel_icon;
  logic          sel_erase;
  logic [IW-1:0] pidx;
  int            prow, pcol;
  logic [7:0]    p_x;
  logic [6:0]    p_y;
  logic [2:0]    p_colour;
  logic          p_plot;

  always_comb begin
    sel_x     = (state == IDLE) ? req_x     : base_x;
    sel_y     = (state == IDLE) ? req_y     : base_y;
    sel_icon  = (state == IDLE) ? req_icon  : icon;
    sel_erase = (state == IDLE) ? req_erase : erase;
    pidx      = (state == IDLE) ? '0 : cnt + 1'b1;
    pcol      = int'(pidx[CW-1:0]);
    prow      = int'(pidx[IW-1:CW]);
    p_x       = sel_x + 8'(pcol);
    p_y       = sel_y + 7'(prow);
    p_colour  = pix_colour(sel_icon, sel_erase, prow, pcol);
    // clip on the unwrapped sum so off-screen pixels never wrap onto the screen
    p_plot    = (int'(sel_x) + pcol < SCREEN_W) && (int'(sel_y) + prow < SCREEN_H);
  end

  assign req_ready = (state == IDLE) && !reset;
`ifdef ROOM_PLOTTER_CLEAR_ON_RESET_EN
  assign busy = (state == DRAW) || (state == CLEAR);
`else
  assign busy = (state == DRAW);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
`ifdef ROOM_PLOTTER_CLEAR_ON_RESET_EN
      state   <= CLEAR;
      sx      <= '0;
      sy      <= '0;
      clr_fin <= 1'b0;
`else
      state   <= IDLE;
`endif
      base_x     <= '0;
      base_y     <= '0;
      icon       <= '0;
      erase      <= 1'b0;
      cnt        <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      done       <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          base_x     <= req_x;
          base_y     <= req_y;
          icon       <= req_icon;
          erase      <= req_erase;
          cnt        <= '0;
          vga_x      <= p_x;
          vga_y      <= p_y;
          vga_colour <= p_colour;
          vga_plot   <= p_plot;
          state      <= DRAW;
        end
        DRAW: if (cnt == IW'(NPIX-1)) begin
          done  <= 1'b1;
          state <= DONE;
        end else begin
          cnt        <= cnt + 1'b1;
          vga_x      <= p_x;
          vga_y      <= p_y;
          vga_colour <= p_colour;
          vga_plot   <= p_plot;
        end
        DONE: state <= IDLE;
`ifdef ROOM_PLOTTER_CLEAR_ON_RESET_EN
        CLEAR: if (clr_fin) begin
          done  <= 1'b1;
          state <= DONE;
        end else begin
          vga_x      <= 8'(sx);
          vga_y      <= 7'(sy);
          vga_colour <= 3'b000;
          vga_plot   <= 1'b1;
          if (sx == SXW'(SCREEN_W-1)) begin
            sx <= '0;
            if (sy == SYW'(SCREEN_H-1)) clr_fin <= 1'b1;
            else                        sy <= sy + 1'b1;
          end else begin
            sx <= sx + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_room_icon_plotter.sv
module tb_room_icon_plotter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_x = '0;
  logic [6:0] req_y = '0;
  logic [1:0] req_icon = '0;
  logic       req_erase = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  room_icon_plotter dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_icon(req_icon), .req_erase(req_erase),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
  } pix_t;

  pix_t q[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Row bitmaps, bit c = column c.
  function automatic logic [7:0] row_bits(input logic [1:0] ic, input int r);
    case (ic)
      2'd0: return (r >= 1 && r <= 5) ? 8'b0000_0010 : (r == 6) ? 8'b0111_1110 : 8'h00;
      2'd1: return (r == 1 || r == 6) ? 8'b0011_1110 : (r >= 2 && r <= 5) ? 8'b0100_0010 : 8'h00;
      2'd2: return 8'hff;
      default: return (r == 0 || r == 7) ? 8'hff : 8'b1000_0001;
    endcase
  endfunction

  function automatic logic [2:0] icon_col(input logic [1:0] ic);
    case (ic)
      2'd0: return 3'b110;
      2'd1: return 3'b010;
      2'd2: return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  task automatic push_sprite(input int x, input int y, input logic [1:0] ic, input logic er);
    pix_t e;
    logic [7:0] rb;
    for (int r = 0; r < 8; r++) begin
      rb = row_bits(ic, r);
      for (int c = 0; c < 8; c++) begin
        e.x = 8'(x + c);
        e.y = 7'(y + r);
        e.c = (er || !rb[c]) ? 3'b000 : icon_col(ic);
        e.p = (x + c < 160) && (y + r < 120);
        q.push_back(e);
      end
    end
  endtask

  task automatic check_pix(input string tag);
    pix_t e;
    if (q.size() == 0) begin
      chk({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk({tag, "_plot"}, {31'd0, vga_plot}, {31'd0, e.p});
      chk({tag, "_x"}, {24'd0, vga_x}, {24'd0, e.x});
      chk({tag, "_y"}, {25'd0, vga_y}, {25'd0, e.y});
      if (e.p) chk({tag, "_colour"}, {29'd0, vga_colour}, {29'd0, e.c});
    end
  endtask

  // Called just after a falling edge with the block in IDLE. Checks npix
  // pixels; for a full sprite also checks the done pulse and the return of
  // req_ready, leaving the bench at the falling edge of cycle N+66.
  task automatic draw(input string tag, input int x, input int y, input logic [1:0] ic,
                      input logic er, input logic hold, input int npix);
    chk({tag, "_ready_pre"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_x = 8'(x); req_y = 7'(y); req_icon = ic; req_erase = er;
    push_sprite(x, y, ic, er);
    @(posedge clock);
    @(negedge clock);
    if (!hold) req_valid = 1'b0;
    for (int i = 0; i < npix; i++) begin
      if (i > 0) @(negedge clock);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
      check_pix(tag);
    end
    if (npix == 64) begin
      @(negedge clock);
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_done_plot"}, {31'd0, vga_plot}, 32'd0);
      chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done_ready"}, {31'd0, req_ready}, 32'd0);
      @(negedge clock);
      chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
      chk({tag, "_ready_post"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_q_drained"}, q.size(), 32'd0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_x"}, {24'd0, vga_x}, 32'd0);
    chk({tag, "_y"}, {25'd0, vga_y}, 32'd0);
    chk({tag, "_colour"}, {29'd0, vga_colour}, 32'd0);
    chk({tag, "_plot"}, {31'd0, vga_plot}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;

`ifdef ROOM_PLOTTER_CLEAR_ON_RESET_EN
    begin
      pix_t e;
      for (int yy = 0; yy < 120; yy++)
        for (int xx = 0; xx < 160; xx++) begin
          e.x = 8'(xx); e.y = 7'(yy); e.c = 3'b000; e.p = 1'b1;
          q.push_back(e);
        end
      for (int i = 0; i < 19200; i++) begin
        @(negedge clock);
        if (i == 100) begin
          req_valid = 1'b1;
          chk("clear_ready_low", {31'd0, req_ready}, 32'd0);
        end
        if (i == 200) req_valid = 1'b0;
        chk("clear_busy", {31'd0, busy}, 32'd1);
        check_pix("clear");
      end
      @(negedge clock);
      chk("clear_done", {31'd0, done}, 32'd1);
      chk("clear_done_plot", {31'd0, vga_plot}, 32'd0);
      @(negedge clock);
      chk("clear_ready", {31'd0, req_ready}, 32'd1);
      chk("clear_done_clr", {31'd0, done}, 32'd0);
    end
`else
    @(negedge clock);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
`endif

    draw("l_10_20", 10, 20, 2'd0, 1'b0, 1'b0, 64);
    draw("solid_clip", 156, 116, 2'd2, 1'b0, 1'b0, 64);
    draw("frame_clip", 152, 112, 2'd3, 1'b0, 1'b0, 64);
    draw("d_40_50", 40, 50, 2'd1, 1'b0, 1'b0, 64);
    // req_valid held through the draw: the next acceptance lands 66 cycles on
    draw("erase_hold1", 0, 0, 2'd3, 1'b1, 1'b1, 64);
    draw("erase_hold2", 0, 0, 2'd3, 1'b1, 1'b0, 64);

    // Abort a D draw with reset during cycle N+30
    draw("d_abort", 30, 40, 2'd1, 1'b0, 1'b0, 30);
    reset = 1'b1;
    q.delete();
    @(negedge clock);
    check_zero("abort");
    reset = 1'b0;
    @(negedge clock);
    chk("abort_nodone", {31'd0, done}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    draw("after_abort", 5, 100, 2'd0, 1'b0, 1'b0, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
